// File: rtl/alu16_core_if.sv
// alu16_core operand/result bundle.
// Master drives the operation, slave returns the registered result.
interface alu16_core_if #(
    parameter int WIDTH = 16
);
    logic [3:0]       FUNC_CODE;
    logic [WIDTH-1:0] OP1;
    logic [WIDTH-1:0] OP2;
    logic [WIDTH-1:0] VALUE0;
    logic [WIDTH-1:0] VALUE1;
    logic             OVERFLOW;
    logic             INVALID;

    modport master (
        output FUNC_CODE, OP1, OP2,
        input  VALUE0, VALUE1, OVERFLOW, INVALID
    );

    modport slave (
        input  FUNC_CODE, OP1, OP2,
        output VALUE0, VALUE1, OVERFLOW, INVALID
    );
endinterface

// File: rtl/alu16_core.sv
// alu16_core: registered signed ALU, one-cycle latency.
// Add/sub/mul/div, rotates and logical shifts with status flags.
module alu16_core #(
    parameter int WIDTH = 16
) (
    input  logic         CLK,
    input  logic         RESET_N,
    alu16_core_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] F_ADD = 4'b1111;
    localparam logic [3:0] F_SUB = 4'b1110;
    localparam logic [3:0] F_MUL = 4'b0001;
    localparam logic [3:0] F_DIV = 4'b0010;
    localparam logic [3:0] F_ROL = 4'b1000;
    localparam logic [3:0] F_ROR = 4'b1001;
    localparam logic [3:0] F_LSR = 4'b1010;
    localparam logic [3:0] F_LSL = 4'b1011;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONE = '1;

    logic [WIDTH-1:0] a, b;
    logic [WIDTH-1:0] sum, diff;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0] n;
    logic [CW:0] n_inv;
    logic [WIDTH-1:0] rol, ror, lsr, lsl;
    logic big_cnt;
    logic div_zero, div_ovf;
    logic signed [WIDTH-1:0] sa, sdiv, quo, rem;

    logic [WIDTH-1:0] value0_d, value0_q;
    logic [WIDTH-1:0] value1_d, value1_q;
    logic ovf_d, ovf_q;
    logic inv_d, inv_q;

    assign a = bus.OP1;
    assign b = bus.OP2;

    // Shared datapath: every operation is computed, the function code selects.
    always_comb begin
        sum = a + b;
        diff = a - b;
        prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        n = b[CW-1:0];
        n_inv = (CW+1)'(WIDTH) - {1'b0, n};
        rol = (a << n) | (a >> n_inv);
        ror = (a >> n) | (a << n_inv);
        big_cnt = |b[WIDTH-1:CW];
        lsr = big_cnt ? '0 : (a >> n);
        lsl = big_cnt ? '0 : (a << n);
        div_zero = (b == '0);
        div_ovf = (a == MIN_NEG) && (b == ALL_ONE);
        sa = a;
        // Keep the divider away from /0 and MIN/-1; those cases are overridden.
        sdiv = (div_zero || div_ovf) ? WIDTH'(1) : b;
        quo = sa / sdiv;
        rem = sa % sdiv;
    end

    // Result select and flag generation for the current function code.
    always_comb begin
        value0_d = '0;
        value1_d = '0;
        ovf_d = 1'b0;
        inv_d = 1'b0;
        unique case (bus.FUNC_CODE)
            F_ADD: begin
                value0_d = sum;
                ovf_d = (a[WIDTH-1] == b[WIDTH-1])
                     && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            F_SUB: begin
                value0_d = diff;
                ovf_d = (a[WIDTH-1] != b[WIDTH-1])
                     && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            F_MUL: begin
                value0_d = prod[WIDTH-1:0];
                value1_d = prod[2*WIDTH-1:WIDTH];
            end
            F_DIV: begin
                if (div_zero) begin
                    inv_d = 1'b1;
                end else if (div_ovf) begin
                    value0_d = MIN_NEG;
                    ovf_d = 1'b1;
                end else begin
                    value0_d = quo;
                    value1_d = rem;
                end
            end
            F_ROL: value0_d = rol;
            F_ROR: value0_d = ror;
            F_LSR: value0_d = lsr;
            F_LSL: value0_d = lsl;
            default: inv_d = 1'b1;
        endcase
    end

    // Output registers; synchronous reset wins over the incoming operation.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            value0_q <= '0;
            value1_q <= '0;
            ovf_q <= 1'b0;
            inv_q <= 1'b0;
        end else begin
            value0_q <= value0_d;
            value1_q <= value1_d;
            ovf_q <= ovf_d;
            inv_q <= inv_d;
        end
    end

    assign bus.VALUE0 = value0_q;
    assign bus.VALUE1 = value1_q;
    assign bus.OVERFLOW = ovf_q;
    assign bus.INVALID = inv_q;
endmodule

// File: tb/tb_alu16_core.sv
// Bench for alu16_core: directed vectors, queued expectations,
// independent monitor comparing one cycle after issue.
module tb_alu16_core;
    logic clk;
    logic rst_n;
    int cyc;
    int tests;
    int fails;

    typedef struct {
        string       name;
        logic [15:0] v0;
        logic [15:0] v1;
        logic        ovf;
        logic        inv;
        int          due;
    } exp_t;

    exp_t sb[$];

    alu16_core_if #(.WIDTH(16)) bus ();

    alu16_core #(.WIDTH(16)) dut (
        .CLK(clk),
        .RESET_N(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle, compare the entry due at this edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due < cyc) begin
            exp_t m;
            m = sb.pop_front();
            tests++;
            fails++;
            $display("FAIL %s: missed, due cycle %0d now %0d",
                     m.name, m.due, cyc);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            tests++;
            if (bus.VALUE0 !== e.v0 || bus.VALUE1 !== e.v1 ||
                bus.OVERFLOW !== e.ovf || bus.INVALID !== e.inv) begin
                fails++;
                $display("FAIL %s: got v1=%h v0=%h ovf=%b inv=%b, want v1=%h v0=%h ovf=%b inv=%b",
                         e.name, bus.VALUE1, bus.VALUE0,
                         bus.OVERFLOW, bus.INVALID,
                         e.v1, e.v0, e.ovf, e.inv);
            end
        end
    end

    task automatic issue(input string name, input logic rst,
                         input logic [3:0] f,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] v1, input logic [15:0] v0,
                         input logic ovf, input logic inv);
        exp_t e;
        @(negedge clk);
        rst_n = rst;
        bus.FUNC_CODE = f;
        bus.OP1 = a;
        bus.OP2 = b;
        e.name = name;
        e.v0 = v0;
        e.v1 = v1;
        e.ovf = ovf;
        e.inv = inv;
        e.due = cyc + 1;
        sb.push_back(e);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.FUNC_CODE = 4'b0000;
        bus.OP1 = 16'h0;
        bus.OP2 = 16'h0;

        issue("rst0", 0, 4'b1111, 16'h1234, 16'h1111, 16'h0, 16'h0, 0, 0);
        issue("rst1", 0, 4'b0001, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 0, 0);
        issue("inv0000", 1, 4'b0000, 16'h1234, 16'h5678, 16'h0, 16'h0, 0, 1);
        issue("inv0111", 1, 4'b0111, 16'hFFFF, 16'h0001, 16'h0, 16'h0, 0, 1);

        issue("add_plain", 1, 4'b1111, 16'h0F00, 16'h0050, 16'h0, 16'h0F50, 0, 0);
        issue("add_ovf1", 1, 4'b1111, 16'h7FFF, 16'h0001, 16'h0, 16'h8000, 1, 0);
        issue("add_ovf2", 1, 4'b1111, 16'h7FFF, 16'h7FFF, 16'h0, 16'hFFFE, 1, 0);
        issue("add_clear", 1, 4'b1111, 16'h0001, 16'h0001, 16'h0, 16'h0002, 0, 0);
        issue("sub_neg", 1, 4'b1110, 16'h0000, 16'h0001, 16'h0, 16'hFFFF, 0, 0);
        issue("sub_ovf", 1, 4'b1110, 16'h8000, 16'h0001, 16'h0, 16'h7FFF, 1, 0);
        issue("rst_mid", 0, 4'b1111, 16'h7FFF, 16'h0001, 16'h0, 16'h0, 0, 0);

        issue("mul_m1x1", 1, 4'b0001, 16'hFFFF, 16'h0001, 16'hFFFF, 16'hFFFF, 0, 0);
        issue("mul_m1x2", 1, 4'b0001, 16'hFFFF, 16'h0002, 16'hFFFF, 16'hFFFE, 0, 0);
        issue("mul_m1xm1", 1, 4'b0001, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 0, 0);
        issue("mul_zero", 1, 4'b0001, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 0, 0);
        issue("mul_big", 1, 4'b0001, 16'h7FFF, 16'h7FFF, 16'h3FFF, 16'h0001, 0, 0);

        issue("div_m1by2", 1, 4'b0010, 16'hFFFF, 16'h0002, 16'hFFFF, 16'h0000, 0, 0);
        issue("div_m1bym1", 1, 4'b0010, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 0, 0);
        issue("div_0by1", 1, 4'b0010, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 0, 0);
        issue("div_by0", 1, 4'b0010, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1);
        issue("div_minbym1", 1, 4'b0010, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1, 0);
        issue("div_neg", 1, 4'b0010, 16'h8001, 16'h0002, 16'hFFFF, 16'hC001, 0, 0);
        issue("div_7by2", 1, 4'b0010, 16'h0007, 16'h0002, 16'h0001, 16'h0003, 0, 0);

        issue("rol_1", 1, 4'b1000, 16'h0001, 16'h0001, 16'h0, 16'h0002, 0, 0);
        issue("rol_2", 1, 4'b1000, 16'h0010, 16'h0002, 16'h0, 16'h0040, 0, 0);
        issue("rol_15", 1, 4'b1000, 16'h0001, 16'hFFFF, 16'h0, 16'h8000, 0, 0);
        issue("ror_1", 1, 4'b1001, 16'h1000, 16'h0001, 16'h0, 16'h0800, 0, 0);
        issue("ror_15", 1, 4'b1001, 16'h1000, 16'hFEFF, 16'h0, 16'h2000, 0, 0);
        issue("ror_wrap", 1, 4'b1001, 16'h0001, 16'h0004, 16'h0, 16'h1000, 0, 0);

        issue("lsr_2", 1, 4'b1010, 16'h1000, 16'h0002, 16'h0, 16'h0400, 0, 0);
        issue("lsr_big", 1, 4'b1010, 16'h1000, 16'hFFFF, 16'h0, 16'h0000, 0, 0);
        issue("lsr_16", 1, 4'b1010, 16'h8000, 16'h0010, 16'h0, 16'h0000, 0, 0);
        issue("lsl_2", 1, 4'b1011, 16'h0001, 16'h0002, 16'h0, 16'h0004, 0, 0);
        issue("lsl_big", 1, 4'b1011, 16'h0001, 16'hFFFF, 16'h0, 16'h0000, 0, 0);
        issue("lsl_0", 1, 4'b1011, 16'h0001, 16'h0000, 16'h0, 16'h0001, 0, 0);

        for (int i = 0; i < 4; i++) @(negedge clk);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu16_core.md
Name: alu16_core

Overview:
- 16-bit registered ALU for the datapath.
- Supports signed add/subtract/multiply/divide, rotates and logical shifts, selected by a 4-bit function code.
- Produces a 32-bit result split across two 16-bit words, plus OVERFLOW and INVALID status flags.
- Inputs are sampled on the rising clock edge; results appear one cycle later.

Parameters:
- WIDTH, 16, operand and result-word width. All behaviour below is stated for 16.

Ports:
- CLK  input  1  rising-edge clock.
- RESET_N  input  1  synchronous, active-low reset.
- FUNC_CODE  input  4  operation select.
- OP1  input  16  first operand: dividend, or the value to shift/rotate.
- OP2  input  16  second operand: divisor, or the shift/rotate count.
- VALUE0  output  16  primary result: sum, difference, low product, quotient, or shifted value.
- VALUE1  output  16  secondary result: high product or remainder; 0 for all other ops.
- OVERFLOW  output  1  signed overflow of the selected operation.
- INVALID  output  1  unsupported FUNC_CODE, or divide by zero.

Behaviour:
- All outputs are registered.
- At each rising CLK edge with RESET_N=1, outputs load the combinational result of the current FUNC_CODE/OP1/OP2.
- Latency is 1 cycle; a new operation is accepted every cycle.
- There is no handshake and no internal state beyond the output registers.
- Reset: RESET_N=0 at a rising edge clears VALUE0, VALUE1, OVERFLOW and INVALID to 0. Reset has priority over any operation in flight.
- Operands are two's-complement for arithmetic ops.
- Function codes:
  - 1111 ADD: VALUE0 = OP1+OP2 (mod 2^16). OVERFLOW=1 when the operands have equal signs and the result sign differs.
  - 1110 SUB: VALUE0 = OP1-OP2 (mod 2^16). OVERFLOW=1 when the operands have different signs and the result sign differs from OP1.
  - 0001 MUL: full signed 32-bit product. VALUE1 = product[31:16], VALUE0 = product[15:0]. OVERFLOW=0.
  - 0010 DIV: signed division truncating toward zero.
    - VALUE0 = quotient; VALUE1 = remainder, with the sign of OP1.
    - OP2=0: INVALID=1, VALUE0=VALUE1=0, OVERFLOW=0.
    - OP1=8000, OP2=FFFF: VALUE0=8000, VALUE1=0, OVERFLOW=1.
  - 1000 ROTATE LEFT: VALUE0 = OP1 rotated left by OP2[3:0]. Upper OP2 bits are ignored (count mod 16).
  - 1001 ROTATE RIGHT: VALUE0 = OP1 rotated right by OP2[3:0].
  - 1010 LOGICAL SHIFT RIGHT: VALUE0 = OP1 >> OP2 (unsigned count, zero fill). A count of 16 or more gives 0.
  - 1011 LOGICAL SHIFT LEFT: VALUE0 = OP1 << OP2 (zero fill). A count of 16 or more gives 0.
  - Any other code: INVALID=1, VALUE0=VALUE1=0, OVERFLOW=0.
- For every op except MUL and DIV, VALUE1=0.
- OVERFLOW=0 for all shift and rotate ops.
- INVALID=0 for all valid, non-faulting ops.
- Flags describe only the operation registered in that cycle; nothing is sticky.
- Implementation may use the synthesizer's signed * and / operators or an equivalent combinational structure. The 1-cycle latency is required regardless of implementation.

Test Plan:
- Reset and invalid code:
  - Hold RESET_N=0 for 2 edges -> all outputs 0.
  - Release reset, FUNC_CODE=0000 -> INVALID=1, values 0.
  - Assert RESET_N=0 mid-stream -> outputs 0 on the next edge.
- ADD/SUB:
  - 0F00+0050 -> VALUE0=0F50, OVERFLOW=0.
  - 7FFF+0001 -> 8000, OVERFLOW=1.
  - 7FFF+7FFF -> FFFE, OVERFLOW=1.
  - SUB 0000-0001 -> FFFF, OVERFLOW=0.
  - SUB 8000-0001 -> 7FFF, OVERFLOW=1.
  - Each result appears exactly one edge after the inputs are applied.
- MUL:
  - FFFF*0001 -> VALUE1:VALUE0 = FFFF:FFFF.
  - FFFF*0002 -> FFFF:FFFE.
  - FFFF*FFFF -> 0000:0001.
  - 0000*0001 -> 0000:0000.
- DIV:
  - FFFF/0002 -> quotient 0000, remainder FFFF.
  - FFFF/FFFF -> 0001, 0000.
  - 0000/0001 -> 0000, 0000.
  - 0000/0000 -> INVALID=1.
  - 8000/FFFF -> 8000, OVERFLOW=1.
- Rotates:
  - ROL 0001 by 0001 -> 0002.
  - ROL 0010 by 0002 -> 0040.
  - ROL 0001 by FFFF -> 8000.
  - ROR 1000 by 0001 -> 0800.
  - ROR 1000 by FEFF -> 2000.
- Shifts:
  - LSR 1000 by 0002 -> 0400.
  - LSR 1000 by FFFF -> 0000.
  - LSL 0001 by 0002 -> 0004.
  - LSL 0001 by FFFF -> 0000.
  - LSL 0001 by 0000 -> 0001.
